// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types for the writeback / register-file slice.
package pipeline_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port with same-cycle writeback bypass.
module rf_read_port #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
    parameter int ADDR_W   = pipeline_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              byp_en_i,
    input  logic [ADDR_W-1:0] byp_addr_i,
    input  logic [DATA_W-1:0] byp_data_i,
    output logic [DATA_W-1:0] rd_o
);

    logic in_range;

    generate
        if (NUM_REGS < (1 << ADDR_W)) begin : g_partial
            assign in_range = (int'(ra_i) < NUM_REGS);
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    always_comb begin
        // NOTE: default assignment first so every path drives rd_o and no latch is inferred.
        rd_o = '0;
        if (ra_i != '0 && in_range) begin
            if (byp_en_i && ra_i == byp_addr_i) begin
                rd_o = byp_data_i;
            end else begin
                rd_o = regs_i[ra_i];
            end
        end
    end

endmodule

// File: rtl/wb_register_file.sv
// Architectural register file: commits the writeback result, serves two bypassed
// read ports and reports each committed write to the hazard unit.
module wb_register_file #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
    parameter int ADDR_W   = pipeline_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              clr,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              wr_commit,
    output logic [ADDR_W-1:0] wr_commit_addr
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_commit_q;
    logic [ADDR_W-1:0] wr_commit_addr_q;
    logic [ADDR_W-1:0] wr_commit_addr_d;

    logic byp_en;
    logic addr_ok;
    logic commit;

    generate
        if (NUM_REGS < (1 << ADDR_W)) begin : g_partial
            assign addr_ok = (int'(wb_addr) < NUM_REGS);
        end else begin : g_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    // Bypass qualifies exactly like a commit except for the address checks,
    // which the read ports apply to their own address.
    assign byp_en = wb_we & ~wb_stall & ~clr;
    assign commit = byp_en & (wb_addr != '0) & addr_ok;

    always_comb begin
        regs_d = regs_q;
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (commit) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    assign wr_commit_addr_d = commit ? wb_addr : wr_commit_addr_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the storage array is reset because reads must return 0 while rst_n is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_commit_q      <= 1'b0;
            wr_commit_addr_q <= '0;
        end else begin
            regs_q           <= regs_d;
            wr_commit_q      <= commit;
            wr_commit_addr_q <= wr_commit_addr_d;
        end
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_port1 (
        .ra_i      (ra1),
        .regs_i    (regs_q),
        .byp_en_i  (byp_en),
        .byp_addr_i(wb_addr),
        .byp_data_i(wb_data),
        .rd_o      (rd1)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_port2 (
        .ra_i      (ra2),
        .regs_i    (regs_q),
        .byp_en_i  (byp_en),
        .byp_addr_i(wb_addr),
        .byp_data_i(wb_data),
        .rd_o      (rd2)
    );

    assign wr_commit      = wr_commit_q;
    assign wr_commit_addr = wr_commit_addr_q;

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Scalar register file at the end of the pipeline.
- Consumes the 16-bit writeback-mux result (ALU result, or 12-bit immediate zero-extended) and commits it to the architectural registers.
- Supplies two combinational read ports to the decode stage.
- Provides write-to-read bypass, hardwired-zero R0, a stall gate and a synchronous clear.

Parameters:
- DATA_W, 16, register and writeback data width
- NUM_REGS, 16, number of architectural registers
- ADDR_W, 4, register address width; must equal clog2(NUM_REGS)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_we  input  1  writeback write enable from the MEM/WB stage
- wb_stall  input  1  pipeline stall; suppresses the commit this cycle
- wb_addr  input  ADDR_W  destination register of the writeback
- wb_data  input  DATA_W  writeback-mux result to commit
- clr  input  1  synchronous clear of all registers
- ra1  input  ADDR_W  read address, port 1
- ra2  input  ADDR_W  read address, port 2
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2
- wr_commit  output  1  registered pulse: a write committed on the previous edge
- wr_commit_addr  output  ADDR_W  registered address of the last committed write

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers clear to 0.
  - wr_commit=0, wr_commit_addr=0.
  - rd1/rd2 therefore read 0 for every address while reset is held.
  - Deassertion is synchronised by the top level; the block only requires rst_n to be asynchronous on assert.
- Commit condition: commit = wb_we & ~wb_stall & ~clr & (wb_addr != 0).
  - On a rising edge with commit=1, reg[wb_addr] <= wb_data.
  - Latency from wb_data to architectural state: 1 edge.
- R0:
  - always reads 0.
  - writes to address 0 are discarded; no commit pulse is generated.
- Reads:
  - purely combinational.
  - rdN = 0 if raN==0.
  - else wb_data if (wb_we & ~wb_stall & ~clr & raN==wb_addr): same-cycle bypass.
  - else reg[raN].
- Bypass rules:
  - The bypass never forwards when the write would not commit (stall, clear, R0).
  - Both ports may bypass simultaneously when ra1==ra2==wb_addr.
- clr (synchronous):
  - on an edge with clr=1, all registers become 0 and any concurrent write is dropped (clr has priority over wb_we).
  - During the clr cycle, reads return stored values with no bypass.
- wr_commit:
  - on every edge, wr_commit <= commit.
  - wr_commit_addr <= wb_addr when commit=1; otherwise it holds its value.
  - Used by the hazard unit to retire its scoreboard entry.
- Stall:
  - wb_stall=1 freezes all register contents.
  - wr_commit goes to 0 on the next edge.
  - Reads continue to return stored values.
- Out-of-range addresses: when NUM_REGS < 2^ADDR_W, writes to addresses >= NUM_REGS are discarded and reads of them return 0.
- Width rule: no truncation or extension inside the block. wb_data arrives already 16 bits wide; immediate zero-extension is done upstream.
- Reset mid-operation: asynchronous reset overrides any commit in flight. No partial write may be observable after rst_n rises.

Decomposition:
- Shared pipeline package (pipeline_pkg):
  - DATA_W, ADDR_W, NUM_REGS constants.
  - typedef logic [DATA_W-1:0] word_t.
  - typedef logic [ADDR_W-1:0] reg_addr_t.
  - localparam REG_ZERO = 0.
- One natural sub-module: rf_read_port.
  - Combinational: address, storage array view and writeback bypass inputs in; rdN out.
  - Instantiated twice to keep the two ports identical.
- Storage array, commit logic and wr_commit registers stay in the top module.

Test Plan:
- Reset while registers hold data (write 0xBEEF to R3, then pulse rst_n low mid-cycle) -> rd1 for ra1=3 reads 0x0000 immediately, without waiting for a clock edge; wr_commit=0.
- wb_we=1, wb_addr=5, wb_data=0x0ABC, ra1=5 in the same cycle -> rd1=0x0ABC combinationally (bypass); after the edge, with wb_we=0, rd1 still reads 0x0ABC; wr_commit=1, wr_commit_addr=5 for exactly one cycle.
- Write 0x1234 to R0 with ra1=ra2=0 -> rd1=rd2=0x0000 before and after the edge; wr_commit stays 0.
- R7 holds 0x1111; wb_we=1, wb_stall=1, wb_addr=7, wb_data=0x2222, ra2=7 -> rd2=0x1111 (no bypass); after the edge R7 is still 0x1111; wr_commit=0.
- Fill R1..R15 with 0x00NN (NN = register number), then assert clr together with a write of 0xFFFF to R4 -> after the edge all registers read 0x0000, the R4 write is dropped, wr_commit=0.
- Back-to-back writes to R9 (0x0001 then 0x0002) with ra1=ra2=9 -> rd1 and rd2 track 0x0001 in cycle 1 and 0x0002 in cycle 2; after both edges R9 holds 0x0002.
